// File: rtl/bitty_bus_arb.sv
// Arbiter sharing one single-port SRAM between instruction fetch and data masters.
// Optional BUS_ARB_PERF_EN adds saturating per-master stall-cycle counters.
module bitty_bus_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o
`ifdef BUS_ARB_PERF_EN
    ,
    output logic [31:0] if_stall_cnt_o,
    output logic [31:0] d_stall_cnt_o
`endif
);

    // Handshake: a master holds req (and its command) until it sees gnt in the
    // same cycle; gnt completes the command, reads return with rvalid one cycle later.

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_IF   = 2'd1,
        RD_DATA = 2'd2
    } rd_owner_t;

    rd_owner_t   r_rd_owner;
    rd_owner_t   w_rd_owner_nxt;
    logic [3:0]  r_starve_cnt;
    logic        w_force_if;
    logic        w_if_gnt;
    logic        w_d_gnt;

    // Grants are held off during reset so the memory port goes quiet immediately.
    assign w_force_if = if_req_i & (r_starve_cnt == LIMIT);
    assign w_d_gnt    = ~rst & d_req_i & ~w_force_if;
    assign w_if_gnt   = ~rst & if_req_i & ~w_d_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (!if_req_i || w_if_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (w_d_gnt && r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_owner <= RD_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    always_comb begin
        w_rd_owner_nxt = RD_NONE;
        if (w_if_gnt) begin
            w_rd_owner_nxt = RD_IF;
        end else if (w_d_gnt && !d_we_i) begin
            w_rd_owner_nxt = RD_DATA;
        end
    end

    always_comb begin
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_sel_o   = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (w_d_gnt) begin
            mem_ce_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_sel_o   = d_sel_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (w_if_gnt) begin
            mem_ce_o    = 1'b1;
            mem_sel_o   = 4'hF;
            mem_addr_o  = if_addr_i;
        end
    end

    assign if_gnt_o    = w_if_gnt;
    assign d_gnt_o     = w_d_gnt;
    assign if_rvalid_o = (r_rd_owner == RD_IF);
    assign d_rvalid_o  = (r_rd_owner == RD_DATA);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : 32'h0;
    assign stall_o     = (if_req_i & ~w_if_gnt) | (d_req_i & ~w_d_gnt);

`ifdef BUS_ARB_PERF_EN
    logic [31:0] r_if_stall_cnt;
    logic [31:0] r_d_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_stall_cnt <= 32'h0;
            r_d_stall_cnt  <= 32'h0;
        end else begin
            if (if_req_i && !w_if_gnt && r_if_stall_cnt != 32'hFFFF_FFFF) begin
                r_if_stall_cnt <= r_if_stall_cnt + 32'd1;
            end
            if (d_req_i && !w_d_gnt && r_d_stall_cnt != 32'hFFFF_FFFF) begin
                r_d_stall_cnt <= r_d_stall_cnt + 32'd1;
            end
        end
    end

    assign if_stall_cnt_o = r_if_stall_cnt;
    assign d_stall_cnt_o  = r_d_stall_cnt;
`endif

endmodule

// File: tb/tb_bitty_bus_arb.sv
// Self-checking bench for bitty_bus_arb: vector table, hand-written corner
// sequences and a randomized run against a rule-level reference model.
module tb_bitty_bus_arb;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
`ifdef BUS_ARB_PERF_EN
    logic [31:0] if_stall_cnt_o;
    logic [31:0] d_stall_cnt_o;
`endif

    bitty_bus_arb #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
`ifdef BUS_ARB_PERF_EN
        , .if_stall_cnt_o(if_stall_cnt_o), .d_stall_cnt_o(d_stall_cnt_o)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard state: read-return owner for the coming cycle (0 none, 1 fetch, 2 data)
    logic [1:0] exp_q[$];
    int         m_wait;
    int         m_if_stall;
    int         m_d_stall;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd,
                         input logic [31:0] rd);
        if_req_i = ir; if_addr_i = ia; d_req_i = dr; d_we_i = dw;
        d_sel_i = ds; d_addr_i = da; d_wdata_i = dd; mem_rdata_i = rd;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(2'd0);
        m_wait = 0;
        m_if_stall = 0;
        m_d_stall = 0;
    endtask

    // Reference: data wins unless fetch has already lost STARVE_LIMIT times in a row.
    task automatic model_check();
        logic       e_d, e_if;
        logic [1:0] owner;
        e_d  = d_req_i && !(if_req_i && m_wait >= STARVE_LIMIT);
        e_if = if_req_i && !e_d;
        owner = exp_q.pop_front();
        chk("if_gnt", if_gnt_o, e_if);
        chk("d_gnt", d_gnt_o, e_d);
        chk("mem_ce", mem_ce_o, e_d | e_if);
        chk("mem_we", mem_we_o, e_d & d_we_i);
        chk("mem_sel", mem_sel_o, e_d ? d_sel_i : (e_if ? 4'hF : 4'h0));
        chk("mem_addr", mem_addr_o, e_d ? d_addr_i : (e_if ? if_addr_i : 32'h0));
        chk("mem_wdata", mem_wdata_o, e_d ? d_wdata_i : 32'h0);
        chk("stall", stall_o, (if_req_i && !e_if) || (d_req_i && !e_d));
        chk("if_rvalid", if_rvalid_o, owner == 2'd1);
        chk("d_rvalid", d_rvalid_o, owner == 2'd2);
        chk("if_rdata", if_rdata_o, (owner == 2'd1) ? mem_rdata_i : 32'h0);
        chk("d_rdata", d_rdata_o, (owner == 2'd2) ? mem_rdata_i : 32'h0);
        exp_q.push_back(e_if ? 2'd1 : ((e_d && !d_we_i) ? 2'd2 : 2'd0));
        m_wait = (if_req_i && e_d) ? m_wait + 1 : 0;
        if (if_req_i && !e_if) m_if_stall++;
        if (d_req_i && !e_d) m_d_stall++;
    endtask

    task automatic run_cycle();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        if_req;  logic [31:0] if_addr;
        logic        d_req;   logic        d_we;   logic [3:0] d_sel;
        logic [31:0] d_addr;  logic [31:0] d_wdata; logic [31:0] rdata;
        logic        e_if_gnt; logic e_d_gnt; logic e_stall;
        logic [31:0] e_addr;  logic [3:0] e_sel;  logic e_we; logic [31:0] e_wdata;
        logic        e_if_rv; logic e_d_rv;
    } vec_t;

    vec_t tbl[8];
    logic [3:0] starve_exp[10];
    logic       pat_is_if[10];

    initial begin
        // Fetch x3, idle, fetch+load, load return, store, idle
        tbl[0] = '{1, 32'h100, 0, 0, 4'h0, 32'h0,   32'h0,        32'h0,
                   1, 0, 0, 32'h100, 4'hF, 0, 32'h0,        0, 0};
        tbl[1] = '{1, 32'h100, 0, 0, 4'h0, 32'h0,   32'h0,        32'hDEADBEEF,
                   1, 0, 0, 32'h100, 4'hF, 0, 32'h0,        1, 0};
        tbl[2] = tbl[1];
        tbl[3] = '{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'hDEADBEEF,
                   0, 0, 0, 32'h0,   4'h0, 0, 32'h0,        1, 0};
        tbl[4] = '{1, 32'h104, 1, 0, 4'hF, 32'h200, 32'h55,       32'h0,
                   0, 1, 1, 32'h200, 4'hF, 0, 32'h55,       0, 0};
        tbl[5] = '{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h0BADF00D,
                   0, 0, 0, 32'h0,   4'h0, 0, 32'h0,        0, 1};
        tbl[6] = '{0, 32'h0,   1, 1, 4'h3, 32'h300, 32'h12345678, 32'h0,
                   0, 1, 0, 32'h300, 4'h3, 1, 32'h12345678, 0, 0};
        tbl[7] = '{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'hCAFE0000,
                   0, 0, 0, 32'h0,   4'h0, 0, 32'h0,        0, 0};
        starve_exp = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        pat_is_if  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        chk("rst_if_gnt", if_gnt_o, 0);
        chk("rst_d_gnt", d_gnt_o, 0);
        chk("rst_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
        chk("rst_rdata", if_rdata_o | d_rdata_o, 0);
        chk("rst_mem", {mem_ce_o, mem_we_o, mem_sel_o} | mem_addr_o | mem_wdata_o, 0);
        chk("rst_stall", stall_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].d_req, tbl[i].d_we,
                  tbl[i].d_sel, tbl[i].d_addr, tbl[i].d_wdata, tbl[i].rdata);
            run_cycle();
            chk($sformatf("tbl%0d_if_gnt", i), if_gnt_o, tbl[i].e_if_gnt);
            chk($sformatf("tbl%0d_d_gnt", i), d_gnt_o, tbl[i].e_d_gnt);
            chk($sformatf("tbl%0d_stall", i), stall_o, tbl[i].e_stall);
            chk($sformatf("tbl%0d_addr", i), mem_addr_o, tbl[i].e_addr);
            chk($sformatf("tbl%0d_sel", i), mem_sel_o, tbl[i].e_sel);
            chk($sformatf("tbl%0d_we", i), mem_we_o, tbl[i].e_we);
            chk($sformatf("tbl%0d_wdata", i), mem_wdata_o, tbl[i].e_wdata);
            chk($sformatf("tbl%0d_if_rv", i), if_rvalid_o, tbl[i].e_if_rv);
            chk($sformatf("tbl%0d_d_rv", i), d_rvalid_o, tbl[i].e_d_rv);
        end

        // Starvation: both masters request continuously
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, 32'h1000 + 32'(i * 4), 1, 0, 4'hF, 32'h2000 + 32'(i * 4), 32'h0, $urandom);
            run_cycle();
            chk($sformatf("starve%0d_cnt", i), dut.r_starve_cnt, starve_exp[i]);
            chk($sformatf("starve%0d_if_gnt", i), if_gnt_o, pat_is_if[i]);
            chk($sformatf("starve%0d_d_gnt", i), d_gnt_o, !pat_is_if[i]);
        end

        // Reset right after a load grant drops the pending return
        @(negedge clk);
        drive(0, 0, 1, 0, 4'hF, 32'h400, 32'h0, 32'h0);
        run_cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_d_gnt", d_gnt_o, 0);
        chk("arst_mem", {mem_ce_o, mem_we_o, mem_sel_o} | mem_addr_o | mem_wdata_o, 0);
        @(negedge clk);
        mem_rdata_i = 32'h77777777;
        #1;
        chk("arst_d_rvalid", d_rvalid_o, 0);
        chk("arst_d_rdata", d_rdata_o, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1, 32'h500, 0, 0, 0, 0, 0, 0);
        run_cycle();
        chk("post_rst_if_gnt", if_gnt_o, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5);
        run_cycle();
        chk("post_rst_if_rdata", if_rdata_o, 32'hA5A5A5A5);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, $urandom);
            run_cycle();
        end
`ifdef BUS_ARB_PERF_EN
        #1;
        chk("rand_if_stall_cnt", if_stall_cnt_o, m_if_stall);
        chk("rand_d_stall_cnt", d_stall_cnt_o, m_d_stall);

        // Fetch blocked 7 cycles: 4 losses, a data-only cycle, 3 more losses
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(i != 4, 32'h600, 1, 0, 4'hF, 32'h700, 32'h0, 32'h0);
            run_cycle();
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("perf_if_stall_cnt", if_stall_cnt_o, 32'd7);
        chk("perf_d_stall_cnt", d_stall_cnt_o, 32'd0);
`else
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
